// File: rtl/decode_issue_arbiter.sv
// Two-port round-robin arbiter between decode lanes and the issue register.
// Tags each issued instruction with a free-running major ID.
module decode_issue_arbiter #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64
) (
    input  logic                               clock_i,
    input  logic                               reset_i,
    input  logic                               stall_i,
    input  logic                               flush_i,

    input  logic                               req0Valid_i,
    output logic                               req0Ready_o,
    input  logic [instructionWidth-1:0]        req0Instruction_i,
    input  logic [addressWidth-1:0]            req0Address_i,
    input  logic [PidSize-1:0]                 req0Pid_i,
    input  logic [TidSize-1:0]                 req0Tid_i,

    input  logic                               req1Valid_i,
    output logic                               req1Ready_o,
    input  logic [instructionWidth-1:0]        req1Instruction_i,
    input  logic [addressWidth-1:0]            req1Address_i,
    input  logic [PidSize-1:0]                 req1Pid_i,
    input  logic [TidSize-1:0]                 req1Tid_i,

    output logic                               outputEnable_o,
    output logic [instructionWidth-1:0]        instruction_o,
    output logic [addressWidth-1:0]            instructionAddress_o,
    output logic [PidSize-1:0]                 instructionPid_o,
    output logic [TidSize-1:0]                 instructionTid_o,
    output logic [instructionCounterWidth-1:0] instructionMajId_o,
    output logic                               grant_o
);

    logic                               prio;
    logic [instructionCounterWidth-1:0] majCnt;

    logic                               anyValid;
    logic                               selIdx;
    logic                               canIssue;
    logic                               transfer;
    logic [instructionWidth-1:0]        selInstruction;
    logic [addressWidth-1:0]            selAddress;
    logic [PidSize-1:0]                 selPid;
    logic [TidSize-1:0]                 selTid;

    // With both ports valid the pointer decides; otherwise the lone valid port wins.
    always_comb begin
        anyValid = req0Valid_i | req1Valid_i;
        selIdx   = (req0Valid_i && req1Valid_i) ? prio : req1Valid_i;
        canIssue = reset_i & ~stall_i & ~flush_i;
        transfer = canIssue & anyValid;

        req0Ready_o = transfer & ~selIdx;
        req1Ready_o = transfer & selIdx;

        if (selIdx) begin
            selInstruction = req1Instruction_i;
            selAddress     = req1Address_i;
            selPid         = req1Pid_i;
            selTid         = req1Tid_i;
        end else begin
            selInstruction = req0Instruction_i;
            selAddress     = req0Address_i;
            selPid         = req0Pid_i;
            selTid         = req0Tid_i;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            outputEnable_o       <= 1'b0;
            instruction_o        <= '0;
            instructionAddress_o <= '0;
            instructionPid_o     <= '0;
            instructionTid_o     <= '0;
            instructionMajId_o   <= '0;
            grant_o              <= 1'b0;
            majCnt               <= '0;
            prio                 <= 1'b0;
        end else if (flush_i) begin
            outputEnable_o <= 1'b0;
        end else if (!stall_i) begin
            if (transfer) begin
                outputEnable_o       <= 1'b1;
                instruction_o        <= selInstruction;
                instructionAddress_o <= selAddress;
                instructionPid_o     <= selPid;
                instructionTid_o     <= selTid;
                instructionMajId_o   <= majCnt;
                grant_o              <= selIdx;
                majCnt               <= majCnt + instructionCounterWidth'(1);
                prio                 <= ~selIdx;
            end else begin
                outputEnable_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_arbiter.sv
// Directed bench for decode_issue_arbiter; a narrow-counter instance covers major ID wrap.
module tb_decode_issue_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic        stall;
    logic        flush;
    logic        v0, v1;
    logic [31:0] i0, i1;
    logic [63:0] a0, a1;
    logic [19:0] p0, p1;
    logic [15:0] t0, t1;

    logic        r0, r1, oe, gnt;
    logic [31:0] instr;
    logic [63:0] addr;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [63:0] majId;

    logic        wValid;
    logic        wReady0, wReady1, wOe, wGnt;
    logic [31:0] wInstr;
    logic [63:0] wAddr;
    logic [19:0] wPid;
    logic [15:0] wTid;
    logic [3:0]  wMajId;

    int unsigned vecCount = 0;
    int unsigned errCount = 0;

    always #5 clk = ~clk;

    decode_issue_arbiter dut (
        .clock_i(clk), .reset_i(rstN), .stall_i(stall), .flush_i(flush),
        .req0Valid_i(v0), .req0Ready_o(r0), .req0Instruction_i(i0),
        .req0Address_i(a0), .req0Pid_i(p0), .req0Tid_i(t0),
        .req1Valid_i(v1), .req1Ready_o(r1), .req1Instruction_i(i1),
        .req1Address_i(a1), .req1Pid_i(p1), .req1Tid_i(t1),
        .outputEnable_o(oe), .instruction_o(instr), .instructionAddress_o(addr),
        .instructionPid_o(pid), .instructionTid_o(tid),
        .instructionMajId_o(majId), .grant_o(gnt)
    );

    decode_issue_arbiter #(.instructionCounterWidth(4)) wrapDut (
        .clock_i(clk), .reset_i(rstN), .stall_i(1'b0), .flush_i(1'b0),
        .req0Valid_i(wValid), .req0Ready_o(wReady0), .req0Instruction_i(32'h1234_5678),
        .req0Address_i(64'h2000), .req0Pid_i(20'h1), .req0Tid_i(16'h1),
        .req1Valid_i(1'b0), .req1Ready_o(wReady1), .req1Instruction_i(32'h0),
        .req1Address_i(64'h0), .req1Pid_i(20'h0), .req1Tid_i(16'h0),
        .outputEnable_o(wOe), .instruction_o(wInstr), .instructionAddress_o(wAddr),
        .instructionPid_o(wPid), .instructionTid_o(wTid),
        .instructionMajId_o(wMajId), .grant_o(wGnt)
    );

    task automatic checkVec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        stall = 1'b0; flush = 1'b0; v0 = 1'b0; v1 = 1'b0; wValid = 1'b0;
        tick();
        tick();
        rstN = 1'b1;
    endtask

    initial begin
        i0 = 32'hA000_0000; a0 = 64'h100; p0 = 20'h11; t0 = 16'h21;
        i1 = 32'hB111_1111; a1 = 64'h200; p1 = 20'h12; t1 = 16'h22;

        // Reset state, readies held low even with a valid request
        rstN = 1'b0; stall = 1'b0; flush = 1'b0; v0 = 1'b1; v1 = 1'b0; wValid = 1'b0;
        tick();
        checkVec("rst_ready0", r0, 0);
        checkVec("rst_oe", oe, 0);
        checkVec("rst_instr", instr, 0);
        checkVec("rst_majId", majId, 0);
        checkVec("rst_grant", gnt, 0);
        v0 = 1'b0;
        tick();
        rstN = 1'b1;

        // Single request on port 0
        v0 = 1'b1; i0 = 32'h7C08_02A6; a0 = 64'h1000; p0 = 20'h5; t0 = 16'h3;
        #1;
        checkVec("single_ready0", r0, 1);
        checkVec("single_ready1", r1, 0);
        tick();
        v0 = 1'b0;
        checkVec("single_oe", oe, 1);
        checkVec("single_instr", instr, 64'h7C08_02A6);
        checkVec("single_addr", addr, 64'h1000);
        checkVec("single_pid", pid, 5);
        checkVec("single_tid", tid, 3);
        checkVec("single_majId", majId, 0);
        checkVec("single_grant", gnt, 0);
        tick();
        checkVec("single_oe_drop", oe, 0);
        checkVec("single_instr_hold", instr, 64'h7C08_02A6);
        checkVec("single_majId_hold", majId, 0);

        // Both ports continuously valid: alternate grants, consecutive IDs
        doReset();
        i0 = 32'hA000_0000; a0 = 64'h100;
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            checkVec("rr_grant", gnt, k % 2);
            checkVec("rr_majId", majId, k);
            checkVec("rr_instr", instr, (k % 2) ? 64'hB111_1111 : 64'hA000_0000);
        end

        // Stall after majId 3; unselected-port data changes must not leak
        doReset();
        v0 = 1'b1; v1 = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        checkVec("pre_stall_majId", majId, 3);
        checkVec("pre_stall_grant", gnt, 1);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i1 = 32'hDEAD_0000 + 32'(k);
            #1;
            checkVec("stall_ready0", r0, 0);
            checkVec("stall_ready1", r1, 0);
            tick();
            checkVec("stall_oe", oe, 1);
            checkVec("stall_majId", majId, 3);
            checkVec("stall_instr", instr, 64'hB111_1111);
        end
        stall = 1'b0;
        tick();
        checkVec("post_stall_majId", majId, 4);
        checkVec("post_stall_grant", gnt, 0);
        checkVec("post_stall_instr", instr, 64'hA000_0000);

        // Flush overrides stall
        v0 = 1'b0; v1 = 1'b1; i1 = 32'hC222_2222; stall = 1'b1; flush = 1'b1;
        #1;
        checkVec("flush_ready1", r1, 0);
        tick();
        checkVec("flush_oe", oe, 0);
        checkVec("flush_majId_hold", majId, 4);
        checkVec("flush_instr_hold", instr, 64'hA000_0000);
        stall = 1'b0; flush = 1'b0;
        #1;
        checkVec("after_flush_ready1", r1, 1);
        tick();
        checkVec("after_flush_majId", majId, 5);
        checkVec("after_flush_grant", gnt, 1);
        checkVec("after_flush_instr", instr, 64'hC222_2222);

        // No requester: enable drops, everything else holds
        v1 = 1'b0;
        tick();
        checkVec("idle_oe", oe, 0);
        checkVec("idle_grant", gnt, 1);
        checkVec("idle_majId", majId, 5);
        v0 = 1'b1;
        tick();
        checkVec("idle_next_majId", majId, 6);

        // Asynchronous reset mid-stall, between edges
        v0 = 1'b1; v1 = 1'b1; stall = 1'b1;
        #2;
        rstN = 1'b0;
        #1;
        checkVec("areset_oe", oe, 0);
        checkVec("areset_instr", instr, 0);
        checkVec("areset_majId", majId, 0);
        checkVec("areset_ready0", r0, 0);
        tick();
        #2;
        rstN = 1'b1; stall = 1'b0;
        tick();
        checkVec("areset_first_majId", majId, 0);
        checkVec("areset_first_grant", gnt, 0);

        // Major ID wrap on the narrow-counter instance
        doReset();
        wValid = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            if (k == 15) checkVec("wrap_max", 64'(wMajId), 64'hF);
            if (k == 16) checkVec("wrap_zero", 64'(wMajId), 0);
        end
        wValid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/decode_issue_arbiter.md
DECODE_ISSUE_ARBITER -- requirements
Module: decode_issue_arbiter

Interface
REQ-001 SHALL have parameter addressWidth, default 64, instruction address width.
REQ-002 SHALL have parameter instructionWidth, default 32, instruction word width.
REQ-003 SHALL have parameter PidSize, default 20, process ID width.
REQ-004 SHALL have parameter TidSize, default 16, thread ID width.
REQ-005 SHALL have parameter instructionCounterWidth, default 64, major ID width.
REQ-006 SHALL have port clock_i  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset_i  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port stall_i  in  1  downstream format-scan stall.
REQ-009 SHALL have port flush_i  in  1  pipeline flush.
REQ-010 SHALL have, for N in {0,1}: reqNValid_i in 1; reqNReady_o out 1; reqNInstruction_i in instructionWidth; reqNAddress_i in addressWidth; reqNPid_i in PidSize; reqNTid_i in TidSize.
REQ-011 SHALL have outputs outputEnable_o 1, instruction_o instructionWidth, instructionAddress_o addressWidth, instructionPid_o PidSize, instructionTid_o TidSize, instructionMajId_o instructionCounterWidth, grant_o 1 (index of the requester that supplied the current output).

Function
REQ-012 A transfer on port N SHALL occur at a rising edge where reqNValid_i=1 and reqNReady_o=1; at most one transfer per cycle.
REQ-013 reqNReady_o SHALL be combinational: 1 only when stall_i=0, flush_i=0, and port N is the selected requester.
REQ-014 Selection SHALL be: only one port valid -> that port; both valid -> port named by priority pointer prio; none valid -> no selection.
REQ-015 prio SHALL be a 1-bit register; on a transfer from port N it SHALL become 1-N; otherwise it SHALL hold.
REQ-016 Output register SHALL have 1-cycle latency: a transfer at edge k presents its fields on outputs after edge k with outputEnable_o=1.
REQ-017 instructionMajId_o SHALL carry the value of an internal counter majCnt at transfer; majCnt SHALL increment by 1 per transfer only.
REQ-018 majCnt SHALL wrap from 2^instructionCounterWidth-1 to 0 without error indication.
REQ-019 grant_o SHALL be loaded with the transferring port index together with the data fields.
REQ-020 stall_i=1, flush_i=0: all outputs, majCnt and prio SHALL hold; both readies SHALL be 0.
REQ-021 stall_i=0, flush_i=0, no selection: outputEnable_o SHALL become 0 at the edge; data outputs, grant_o, majCnt and prio SHALL hold.
REQ-022 flush_i=1 SHALL override stall_i: outputEnable_o SHALL become 0 at the edge; no transfer; majCnt, prio and data outputs SHALL hold.
REQ-023 Requester data SHALL be sampled only on a transfer edge; changes on an unselected port SHALL NOT affect outputs.
REQ-024 A requester holding valid continuously SHALL be granted within 2 non-stalled, non-flushed cycles (round-robin, no starvation).

Reset
REQ-025 While reset_i=0, independent of clock: outputEnable_o=0, all data outputs=0, grant_o=0, majCnt=0, prio=0.
REQ-026 Reset asserted mid-stall or mid-transfer SHALL discard any in-flight instruction; the first transfer after release SHALL carry majId 0.
REQ-027 Readies SHALL be 0 while reset_i=0.

Verification
REQ-028 Reset release, req0 valid with instr 0x7C0802A6, addr 0x1000 for one cycle -> next cycle outputEnable_o=1, instruction_o=0x7C0802A6, address 0x1000, majId 0, grant_o=0; following cycle outputEnable_o=0.
REQ-029 Both ports valid continuously for 6 cycles -> grant_o sequence 0,1,0,1,0,1; majId 0..5 consecutive.
REQ-030 Transfer at majId 3 then stall_i=1 for 3 cycles with both valid -> readies 0, outputs frozen at majId 3; after stall_i=0 next output majId 4 from the port opposite the last grant.
REQ-031 flush_i=1 together with stall_i=1 and req1 valid -> outputEnable_o=0 next edge, req1Ready_o=0, majCnt unchanged.
REQ-032 Preload majCnt to all-ones via 2^64-1 forced transfers (or force/deposit) -> output majId 0xFFFF_FFFF_FFFF_FFFF then 0.
REQ-033 reset_i=0 asserted between clock edges during a stall -> outputs clear immediately; after release, first transfer majId 0, grant_o=0 when both ports valid.
